// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing one single-port data BlockRam between the host
// debug port and the core load/store unit, with lock ownership and lock timeout.
module data_ram_arbiter #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16,
    parameter int LOCK_TIMEOUT  = 16
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     host_req,
    input  logic                     host_write,
    input  logic                     host_lock,
    input  logic [ADDRESS_WIDTH-1:0] host_address,
    input  logic [WORD_WIDTH-1:0]    host_write_data,
    output logic                     host_grant,
    output logic                     host_read_valid,
    output logic [WORD_WIDTH-1:0]    host_read_data,

    input  logic                     core_req,
    input  logic                     core_write,
    input  logic                     core_lock,
    input  logic [ADDRESS_WIDTH-1:0] core_address,
    input  logic [WORD_WIDTH-1:0]    core_write_data,
    output logic                     core_grant,
    output logic                     core_read_valid,
    output logic [WORD_WIDTH-1:0]    core_read_data,

    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic                     ram_write,
    output logic [WORD_WIDTH-1:0]    ram_write_data,
    input  logic [WORD_WIDTH-1:0]    ram_read_data,

    output logic                     lock_error
);

    localparam logic [1:0] ST_ARB       = 2'd0;
    localparam logic [1:0] ST_LOCK_HOST = 2'd1;
    localparam logic [1:0] ST_LOCK_CORE = 2'd2;

    localparam int            COUNT_WIDTH = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(LOCK_TIMEOUT - 1);

    logic [1:0]             state_reg, state_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic                   last_winner_core_reg, last_winner_core_next;
    logic                   lock_error_reg, lock_error_next;
    logic                   host_grant_w, core_grant_w;

    // Grant decision: lock owner only while locked, round-robin otherwise.
    always_comb begin
        host_grant_w = 1'b0;
        core_grant_w = 1'b0;
        case (state_reg)
            ST_LOCK_HOST: host_grant_w = host_req;
            ST_LOCK_CORE: core_grant_w = core_req;
            default: begin
                if (host_req && core_req) begin
                    host_grant_w = last_winner_core_reg;
                    core_grant_w = !last_winner_core_reg;
                end else begin
                    host_grant_w = host_req;
                    core_grant_w = core_req;
                end
            end
        endcase
    end

    assign host_grant = host_grant_w;
    assign core_grant = core_grant_w;

    always_comb begin
        ram_address    = '0;
        ram_write      = 1'b0;
        ram_write_data = '0;
        if (host_grant_w) begin
            ram_address    = host_address;
            ram_write      = host_write;
            ram_write_data = host_write_data;
        end else if (core_grant_w) begin
            ram_address    = core_address;
            ram_write      = core_write;
            ram_write_data = core_write_data;
        end
    end

    // Timeout is checked before the owner's unlock so it always wins.
    always_comb begin
        state_next            = state_reg;
        count_next            = count_reg;
        lock_error_next       = lock_error_reg;
        last_winner_core_next = last_winner_core_reg;
        if (host_grant_w)
            last_winner_core_next = 1'b0;
        else if (core_grant_w)
            last_winner_core_next = 1'b1;
        case (state_reg)
            ST_ARB: begin
                if (host_grant_w && host_lock) begin
                    state_next = ST_LOCK_HOST;
                    count_next = '0;
                end else if (core_grant_w && core_lock) begin
                    state_next = ST_LOCK_CORE;
                    count_next = '0;
                end
            end
            ST_LOCK_HOST, ST_LOCK_CORE: begin
                if (count_reg == LAST_COUNT) begin
                    state_next      = ST_ARB;
                    lock_error_next = 1'b1;
                end else if ((state_reg == ST_LOCK_HOST && host_grant_w && !host_lock) ||
                             (state_reg == ST_LOCK_CORE && core_grant_w && !core_lock)) begin
                    state_next = ST_ARB;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: state_next = ST_ARB;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg            <= ST_ARB;
            count_reg            <= '0;
            last_winner_core_reg <= 1'b1;
            lock_error_reg       <= 1'b0;
        end else begin
            state_reg            <= state_next;
            count_reg            <= count_next;
            last_winner_core_reg <= last_winner_core_next;
            lock_error_reg       <= lock_error_next;
        end
    end

    assign lock_error = lock_error_reg;

    // Read response path, index 0 = host, 1 = core.
    logic [1:0]            read_grant;
    logic [1:0]            read_valid_reg;
    logic [WORD_WIDTH-1:0] read_data_w [2];

    assign read_grant = {core_grant_w & ~core_write, host_grant_w & ~host_write};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            always_ff @(posedge clock) begin
                if (reset)
                    read_valid_reg[gi] <= 1'b0;
                else
                    read_valid_reg[gi] <= read_grant[gi];
            end
            assign read_data_w[gi] = read_valid_reg[gi] ? ram_read_data : '0;
        end
    endgenerate

    assign host_read_valid = read_valid_reg[0];
    assign host_read_data  = read_data_w[0];
    assign core_read_valid = read_valid_reg[1];
    assign core_read_data  = read_data_w[1];

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a 1-cycle-latency BlockRam model.
module tb_data_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        host_req = 0, host_write = 0, host_lock = 0;
    logic [15:0] host_address = 0;
    logic [31:0] host_write_data = 0;
    logic        host_grant, host_read_valid;
    logic [31:0] host_read_data;
    logic        core_req = 0, core_write = 0, core_lock = 0;
    logic [15:0] core_address = 0;
    logic [31:0] core_write_data = 0;
    logic        core_grant, core_read_valid;
    logic [31:0] core_read_data;
    logic [15:0] ram_address;
    logic        ram_write;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data = 0;
    logic        lock_error;

    logic [31:0] mem [0:255];
    int          tests = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    // BlockRam model: read-before-write, contents reloaded while reset is high.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h01] <= 32'h1111_1111;
            mem[8'h02] <= 32'h2222_2222;
            mem[8'h07] <= 32'h7777_7777;
            mem[8'h10] <= 32'hCAFE_F00D;
        end else if (ram_write) begin
            mem[ram_address[7:0]] <= ram_write_data;
        end
        ram_read_data <= mem[ram_address[7:0]];
    end

    data_ram_arbiter #(.WORD_WIDTH(32), .ADDRESS_WIDTH(16), .LOCK_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .host_req(host_req), .host_write(host_write), .host_lock(host_lock),
        .host_address(host_address), .host_write_data(host_write_data),
        .host_grant(host_grant), .host_read_valid(host_read_valid),
        .host_read_data(host_read_data),
        .core_req(core_req), .core_write(core_write), .core_lock(core_lock),
        .core_address(core_address), .core_write_data(core_write_data),
        .core_grant(core_grant), .core_read_valid(core_read_valid),
        .core_read_data(core_read_data),
        .ram_address(ram_address), .ram_write(ram_write),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
        .lock_error(lock_error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        host_req = 0; host_write = 0; host_lock = 0;
        core_req = 0; core_write = 0; core_lock = 0;
    endtask

    task automatic do_reset();
        idle_all();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        #2;
        check("rst host_read_valid", 32'(host_read_valid), 32'd0);
        check("rst core_read_valid", 32'(core_read_valid), 32'd0);
        check("rst lock_error", 32'(lock_error), 32'd0);
        check("rst no grant", 32'({host_grant, core_grant}), 32'd0);
        step();

        // 1: host-only read
        host_req = 1; host_write = 0; host_address = 16'h0010;
        #2;
        check("t1 host_grant", 32'(host_grant), 32'd1);
        check("t1 core_grant", 32'(core_grant), 32'd0);
        check("t1 ram_address", 32'(ram_address), 32'h10);
        step();
        host_req = 0;
        #2;
        check("t1 host_read_valid", 32'(host_read_valid), 32'd1);
        check("t1 host_read_data", host_read_data, 32'hCAFE_F00D);
        check("t1 core_read_valid", 32'(core_read_valid), 32'd0);
        check("t1 core_read_data", core_read_data, 32'd0);
        step();

        // 2: continuous conflict, alternating grants
        do_reset();
        host_req = 1; host_write = 0; host_address = 16'h0001;
        core_req = 1; core_write = 0; core_address = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            #2;
            check($sformatf("t2 host_grant[%0d]", i), 32'(host_grant), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t2 core_grant[%0d]", i), 32'(core_grant), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check($sformatf("t2 host_read_data[%0d]", i), host_read_data,
                      ((i - 1) % 2 == 0) ? 32'h1111_1111 : 32'h0);
                check($sformatf("t2 core_read_data[%0d]", i), core_read_data,
                      ((i - 1) % 2 == 1) ? 32'h2222_2222 : 32'h0);
            end
            step();
        end
        idle_all();
        #2;
        check("t2 core_read_valid last", 32'(core_read_valid), 32'd1);
        check("t2 host_read_valid last", 32'(host_read_valid), 32'd0);
        step();

        // 3: core locked write then unlocking read, host held off
        do_reset();
        core_req = 1; core_write = 1; core_lock = 1;
        core_address = 16'h0005; core_write_data = 32'h1234_5678;
        #2;
        check("t3 core_grant lock write", 32'(core_grant), 32'd1);
        check("t3 ram_write", 32'(ram_write), 32'd1);
        check("t3 ram_write_data", ram_write_data, 32'h1234_5678);
        step();
        core_req = 0; core_lock = 0;
        host_req = 1; host_write = 0; host_address = 16'h0010;
        #2;
        check("t3 host blocked idle lock", 32'(host_grant), 32'd0);
        step();
        core_req = 1; core_write = 0; core_lock = 0;
        #2;
        check("t3 core_grant unlock read", 32'(core_grant), 32'd1);
        check("t3 host blocked unlock", 32'(host_grant), 32'd0);
        step();
        core_req = 0;
        #2;
        check("t3 core_read_valid", 32'(core_read_valid), 32'd1);
        check("t3 core_read_data", core_read_data, 32'h1234_5678);
        check("t3 host_grant after unlock", 32'(host_grant), 32'd1);
        step();
        host_req = 0;
        #2;
        check("t3 host_read_data", host_read_data, 32'hCAFE_F00D);
        step();

        // 4: host lock timeout
        do_reset();
        host_req = 1; host_write = 0; host_lock = 1; host_address = 16'h0010;
        #2;
        check("t4 host_grant lock", 32'(host_grant), 32'd1);
        step();
        host_req = 0; host_lock = 0;
        core_req = 1; core_write = 0; core_address = 16'h0002;
        for (int k = 1; k <= 16; k++) begin
            #2;
            check($sformatf("t4 core held cyc%0d", k), 32'(core_grant), 32'd0);
            check($sformatf("t4 lock_error cyc%0d", k), 32'(lock_error), 32'd0);
            step();
        end
        #2;
        check("t4 core_grant after timeout", 32'(core_grant), 32'd1);
        check("t4 lock_error set", 32'(lock_error), 32'd1);
        step();
        core_req = 0;
        #2;
        check("t4 lock_error sticky", 32'(lock_error), 32'd1);
        check("t4 core_read_data", core_read_data, 32'h2222_2222);
        step();

        // 5: reset drops an in-flight read
        do_reset();
        core_req = 1; core_write = 0; core_address = 16'h0002;
        #2;
        check("t5 core_grant", 32'(core_grant), 32'd1);
        reset = 1;
        step();
        reset = 0; core_req = 0;
        #2;
        check("t5 core_read_valid dropped", 32'(core_read_valid), 32'd0);
        check("t5 core_read_data dropped", core_read_data, 32'd0);
        check("t5 lock_error cleared", 32'(lock_error), 32'd0);
        host_req = 1; host_address = 16'h0001;
        core_req = 1;
        #1;
        check("t5 conflict host_grant", 32'(host_grant), 32'd1);
        check("t5 conflict core_grant", 32'(core_grant), 32'd0);
        idle_all();
        step();

        // 6: same-address core write / host read conflict
        do_reset();
        core_req = 1; core_write = 1; core_address = 16'h0007; core_write_data = 32'hDEAD_BEEF;
        host_req = 1; host_write = 0; host_address = 16'h0007; host_write_data = 32'hAAAA_5555;
        #2;
        check("t6 host_grant", 32'(host_grant), 32'd1);
        check("t6 core_grant", 32'(core_grant), 32'd0);
        check("t6 ram_write host cycle", 32'(ram_write), 32'd0);
        check("t6 ram_address", 32'(ram_address), 32'h7);
        check("t6 ram_write_data follows host", ram_write_data, 32'hAAAA_5555);
        step();
        host_req = 0;
        #2;
        check("t6 core_grant second", 32'(core_grant), 32'd1);
        check("t6 ram_write core cycle", 32'(ram_write), 32'd1);
        check("t6 ram_write_data core", ram_write_data, 32'hDEAD_BEEF);
        check("t6 host_read_data old", host_read_data, 32'h7777_7777);
        step();
        core_req = 0;
        #2;
        check("t6 idle ram_address", 32'(ram_address), 32'd0);
        check("t6 idle ram_write", 32'(ram_write), 32'd0);
        check("t6 idle ram_write_data", ram_write_data, 32'd0);
        check("t6 write no core_read_valid", 32'(core_read_valid), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
